// File: rtl/pull_responder.sv
// pull_responder: a Depth-entry FIFO filled from a valid/ready push port and
// drained one word per request through a req/ack pull port. Each ack is
// delayed by at least MinLatency extra wait cycles.
// Optional feature: define PULL_RESPONDER_ERR_EN to compile in detection of a
// request dropped before it was acknowledged (sticky err_o). Without it,
// err_o is tied to 0.

module pull_responder #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 4,
  parameter int unsigned MinLatency = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [DataWidth-1:0]     push_data_i,
  input  logic                     pull_req_i,
  output logic                     pull_ack_o,
  output logic [DataWidth-1:0]     pull_data_o,
  output logic [$clog2(Depth):0]   depth_o,
  output logic                     err_o
);

  localparam int unsigned PtrW      = $clog2(Depth);
  localparam logic [PtrW:0] FullLevel = (PtrW+1)'(Depth);
  localparam logic [3:0]    LatInit   = 4'(MinLatency);
  localparam bit            NoLatency = (MinLatency == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   mem_q [Depth];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          depth_q;
  logic [3:0]             cnt_q, cnt_d;
  logic [DataWidth-1:0]   data_q;
  logic                   fifo_empty;
  logic                   push_fire;
  logic                   pop_fire;
  logic                   lat_done;

  assign fifo_empty   = (depth_q == '0);
  assign push_ready_o = ~rst_i & (depth_q != FullLevel);
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = (state_q == ACK);
  assign depth_o      = depth_q;
  assign pull_data_o  = data_q;

  // The IDLE cycle that sees the request already counts as one of the
  // MinLatency cycles, so WAIT may leave once at most one count remains.
  // This gives ack exactly 1 + MinLatency cycles after req is first sampled.
  assign lat_done = (cnt_q <= 4'd1);

  // FIFO storage: written on an accepted push, no reset needed on contents.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // FIFO pointers and occupancy; pops happen only at the end of an ACK cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      depth_q  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_fire, pop_fire})
        2'b10:   depth_q <= depth_q + 1'b1;
        2'b01:   depth_q <= depth_q - 1'b1;
        default: depth_q <= depth_q;
      endcase
    end
  end

  // FSM state register and latency counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state and counter logic; decisions use registered occupancy
  // only, so a word pushed this cycle cannot be acked before the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pull_req_i) begin
          cnt_d = LatInit;
          if (!fifo_empty && NoLatency) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (!pull_req_i) begin
          state_d = IDLE;
        end else if (lat_done && !fifo_empty) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: ack is asserted for the single ACK cycle.
  always_comb begin
    pull_ack_o = 1'b0;
    if (state_q == ACK) begin
      pull_ack_o = 1'b1;
    end
  end

  // Returned payload: captured from the FIFO head on entry to ACK and held
  // until the next ack. The head cannot change before that pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (state_d == ACK && state_q != ACK) begin
      data_q <= mem_q[rd_ptr_q];
    end
  end

`ifdef PULL_RESPONDER_ERR_EN
  logic err_q;

  // Sticky error: request withdrawn while still waiting for its ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (state_q == WAIT && !pull_req_i) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pull_responder.sv
// Bench for pull_responder: cycle table for the FIFO/handshake scenarios,
// a data scoreboard on the main instance, and hand-written sequences for
// the waiting, latency, error and reset corner cases.

module tb_pull_responder;

  localparam int DW = 8;

`ifdef PULL_RESPONDER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Main instance, MinLatency = 0
  logic          push_valid, push_ready, pull_req, pull_ack, err;
  logic [DW-1:0] push_data, pull_data;
  logic [2:0]    depth;

  // Latency instance, MinLatency = 3
  logic          push_valid_l, push_ready_l, pull_req_l, pull_ack_l, err_l;
  logic [DW-1:0] push_data_l, pull_data_l;
  logic [2:0]    depth_l;

  always #5 clk = ~clk;

  pull_responder #(.DataWidth(DW), .Depth(4), .MinLatency(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(push_valid), .push_ready_o(push_ready), .push_data_i(push_data),
    .pull_req_i(pull_req), .pull_ack_o(pull_ack), .pull_data_o(pull_data),
    .depth_o(depth), .err_o(err)
  );

  pull_responder #(.DataWidth(DW), .Depth(4), .MinLatency(3)) dut_l (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(push_valid_l), .push_ready_o(push_ready_l), .push_data_i(push_data_l),
    .pull_req_i(pull_req_l), .pull_ack_o(pull_ack_l), .pull_data_o(pull_data_l),
    .depth_o(depth_l), .err_o(err_l)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] sb[$];
  logic req_q;

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic          req;
    logic          exp_ready;
    logic [2:0]    exp_depth;
    logic          exp_ack;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic pv, input logic [DW-1:0] pd, input logic req,
                              input logic er, input logic [2:0] ed, input logic ea);
    vec_t v;
    v.pv = pv; v.pd = pd; v.req = req;
    v.exp_ready = er; v.exp_depth = ed; v.exp_ack = ea;
    tbl.push_back(v);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request as sampled by the DUT at the edge that starts the current cycle
  always @(posedge clk) req_q <= pull_req;

  // Scoreboard: accepted pushes enqueue, every ack must return the oldest word
  always @(negedge clk) begin
    if (!rst) begin
      if (pull_ack) begin
        chk("ack_after_req", {31'd0, req_q}, 32'd1);
        chk("model_nonempty_on_ack", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) chk("ack_data", {24'd0, pull_data}, {24'd0, sb.pop_front()});
      end
      if (push_valid && push_ready) sb.push_back(push_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    push_valid = 0; push_data = '0; pull_req = 0;
    push_valid_l = 0; push_data_l = '0; pull_req_l = 0;

    // Push three, then three handshakes; depth 3,2,1,0
    add(1, 8'hA1, 0, 1, 3'd0, 0);
    add(1, 8'hB2, 0, 1, 3'd1, 0);
    add(1, 8'hC3, 0, 1, 3'd2, 0);
    add(0, 8'h00, 1, 1, 3'd3, 0);
    add(0, 8'h00, 0, 1, 3'd3, 1);
    add(0, 8'h00, 1, 1, 3'd2, 0);
    add(0, 8'h00, 0, 1, 3'd2, 1);
    add(0, 8'h00, 1, 1, 3'd1, 0);
    add(0, 8'h00, 0, 1, 3'd1, 1);
    add(0, 8'h00, 0, 1, 3'd0, 0);
    // Fill to full, 5th word waits until the cycle after a pop
    add(1, 8'h01, 0, 1, 3'd0, 0);
    add(1, 8'h02, 0, 1, 3'd1, 0);
    add(1, 8'h03, 0, 1, 3'd2, 0);
    add(1, 8'h04, 0, 1, 3'd3, 0);
    add(1, 8'h05, 1, 0, 3'd4, 0);
    add(1, 8'h05, 0, 0, 3'd4, 1);
    add(1, 8'h05, 0, 1, 3'd3, 0);
    add(0, 8'h00, 0, 0, 3'd4, 0);
    // Request held across acks; push during an ack keeps depth
    add(0, 8'h00, 1, 0, 3'd4, 0);
    add(0, 8'h00, 1, 0, 3'd4, 1);
    add(0, 8'h00, 1, 1, 3'd3, 0);
    add(1, 8'h06, 1, 1, 3'd3, 1);
    add(0, 8'h00, 1, 1, 3'd3, 0);
    add(0, 8'h00, 1, 1, 3'd3, 1);
    add(0, 8'h00, 1, 1, 3'd2, 0);
    add(0, 8'h00, 1, 1, 3'd2, 1);
    add(0, 8'h00, 1, 1, 3'd1, 0);
    add(0, 8'h00, 0, 1, 3'd1, 1);
    add(0, 8'h00, 0, 1, 3'd0, 0);

    // Reset values
    #1 rst = 1;
    #1;
    chk("rst_ready", {31'd0, push_ready}, 32'd0);
    chk("rst_depth", {29'd0, depth}, 32'd0);
    chk("rst_ack", {31'd0, pull_ack}, 32'd0);
    chk("rst_data", {24'd0, pull_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, push_ready}, 32'd1);
    next_cycle();

    // Table-driven cycles
    for (int i = 0; i < tbl.size(); i++) begin
      push_valid = tbl[i].pv; push_data = tbl[i].pd; pull_req = tbl[i].req;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'd0, push_ready}, {31'd0, tbl[i].exp_ready});
      chk($sformatf("vec%0d_depth", i), {29'd0, depth}, {29'd0, tbl[i].exp_depth});
      chk($sformatf("vec%0d_ack", i), {31'd0, pull_ack}, {31'd0, tbl[i].exp_ack});
      next_cycle();
    end
    push_valid = 0; pull_req = 0;
    next_cycle();

    // Request on empty FIFO, word arrives late, no fall-through
    pull_req = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("empty_wait%0d_ack", k), {31'd0, pull_ack}, 32'd0);
      next_cycle();
    end
    push_valid = 1; push_data = 8'h55;
    @(negedge clk);
    chk("late_push_ack", {31'd0, pull_ack}, 32'd0);
    next_cycle();
    push_valid = 0;
    @(negedge clk);
    chk("landed_depth", {29'd0, depth}, 32'd1);
    chk("landed_no_fallthrough", {31'd0, pull_ack}, 32'd0);
    next_cycle();
    pull_req = 0;
    @(negedge clk);
    chk("late_ack", {31'd0, pull_ack}, 32'd1);
    chk("late_ack_data", {24'd0, pull_data}, 32'h55);
    next_cycle();
    @(negedge clk);
    chk("data_hold_ack", {31'd0, pull_ack}, 32'd0);
    chk("data_hold", {24'd0, pull_data}, 32'h55);
    chk("depth_after_late", {29'd0, depth}, 32'd0);
    next_cycle();

    // Request withdrawn while waiting on an empty FIFO
    pull_req = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop_wait%0d_ack", k), {31'd0, pull_ack}, 32'd0);
      next_cycle();
    end
    pull_req = 0;
    @(negedge clk);
    chk("drop_err_not_yet", {31'd0, err}, 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("drop_err%0d", k), {31'd0, err}, {31'd0, ERR_EXP});
      chk($sformatf("drop_ack%0d", k), {31'd0, pull_ack}, 32'd0);
      next_cycle();
    end

    // MinLatency = 3: ack exactly 4 cycles after req rises
    push_valid_l = 1; push_data_l = 8'h11;
    next_cycle();
    push_valid_l = 0;
    @(negedge clk);
    chk("lat_depth", {29'd0, depth_l}, 32'd1);
    next_cycle();
    pull_req_l = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_c%0d_ack", k), {31'd0, pull_ack_l}, 32'd0);
      next_cycle();
    end
    pull_req_l = 0;
    @(negedge clk);
    chk("lat_c4_ack", {31'd0, pull_ack_l}, 32'd1);
    chk("lat_c4_data", {24'd0, pull_data_l}, 32'h11);
    next_cycle();
    @(negedge clk);
    chk("lat_depth_after", {29'd0, depth_l}, 32'd0);
    next_cycle();

    // Reset while waiting with two words queued
    push_valid_l = 1; push_data_l = 8'h21;
    next_cycle();
    push_data_l = 8'h22;
    next_cycle();
    push_valid_l = 0; pull_req_l = 1;
    next_cycle();
    next_cycle();
    chk("pre_rst_depth", {29'd0, depth_l}, 32'd2);
    #2 rst = 1;
    #1;
    chk("midrst_depth", {29'd0, depth_l}, 32'd0);
    chk("midrst_ready", {31'd0, push_ready_l}, 32'd0);
    chk("midrst_ack", {31'd0, pull_ack_l}, 32'd0);
    chk("midrst_data", {24'd0, pull_data_l}, 32'd0);
    chk("midrst_err_main", {31'd0, err}, 32'd0);
    sb.delete();
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("postrst_ready", {31'd0, push_ready_l}, 32'd1);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("postrst_wait%0d_ack", k), {31'd0, pull_ack_l}, 32'd0);
      next_cycle();
    end
    push_valid_l = 1; push_data_l = 8'h33;
    @(negedge clk);
    chk("postrst_push_ack", {31'd0, pull_ack_l}, 32'd0);
    next_cycle();
    push_valid_l = 0;
    @(negedge clk);
    chk("postrst_landed_ack", {31'd0, pull_ack_l}, 32'd0);
    next_cycle();
    pull_req_l = 0;
    @(negedge clk);
    chk("postrst_ack", {31'd0, pull_ack_l}, 32'd1);
    chk("postrst_data", {24'd0, pull_data_l}, 32'h33);
    next_cycle();

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
